// File: rtl/sensor_status_pkg.sv
// rtl/sensor_status_pkg.sv - shared constants and OC state encoding for the status conditioner
// Purpose: status word width, bit positions of each flag within the status word, and
//          the overcurrent FSM state type.
// Configuration: OC_STICKY_EN adds the OC_LATCHED state.
package sensor_status_pkg;

    localparam int STATUS_W   = 4;
    localparam int BIT_LEFT   = 3;
    localparam int BIT_CENTER = 2;
    localparam int BIT_RIGHT  = 1;
    localparam int BIT_OC     = 0;

`ifdef OC_STICKY_EN
    typedef enum logic [1:0] {
        OC_IDLE    = 2'd0,
        OC_TRIP    = 2'd1,
        OC_HOLD    = 2'd2,
        OC_LATCHED = 2'd3
    } oc_state_t;
`else
    typedef enum logic [1:0] {
        OC_IDLE = 2'd0,
        OC_TRIP = 2'd1,
        OC_HOLD = 2'd2
    } oc_state_t;
`endif

endpackage

// File: rtl/sensor_status_conditioner_debounce_ch.sv
// rtl/sensor_status_conditioner_debounce_ch.sv - one IR channel: 2-flop sync, debounce counter, stable level
// Purpose: accepts a level change only after DB_CYCLES consecutive synced cycles that
//          disagree with the stable level.
// Ports:
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   raw        in  raw sensor level, asynchronous to clk
//   level_next out value the stable level takes at the next edge
module debounce_ch #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level_next
);
    import sensor_status_pkg::*;

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;

    // The next level is exported so the top can register it without adding a
    // further cycle of latency on top of sync + debounce.
    always_comb begin
        cnt_inc    = cnt + 1'b1;
        cnt_next   = '0;
        level_next = level;
        if (sync2 != level) begin
            if (cnt_inc == CW'(DB_CYCLES)) begin
                level_next = sync2;
            end else begin
                cnt_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            level <= level_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/sensor_status_conditioner.sv
// rtl/sensor_status_conditioner.sv - IR debounce, overcurrent qualify/hold, registered status word
// Purpose: builds the 4-bit status word {LEFT,CENTER,RIGHT,OC} for the display and
//          pulses status_changed for one cycle whenever the word changes.
// Configuration: OC_STICKY_EN makes the OC flag latch after the hold until oc_clear.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ir_left, ir_center, ir_right   raw IR sensors (asynchronous)
//   oc_raw                         raw overcurrent flag (asynchronous, active-high)
//   oc_clear                       overcurrent acknowledge (sticky build only)
//   status                         registered status word
//   status_changed                 one-cycle pulse when status takes a new value
module sensor_status_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int OC_HOLD   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ir_left,
    input  logic                               ir_center,
    input  logic                               ir_right,
    input  logic                               oc_raw,
    input  logic                               oc_clear,
    output logic [sensor_status_pkg::STATUS_W-1:0] status,
    output logic                               status_changed
);
    import sensor_status_pkg::*;

    localparam int HW = (OC_HOLD > 1) ? $clog2(OC_HOLD) : 1;

    logic            left_next;
    logic            center_next;
    logic            right_next;
    logic            oc_s1;
    logic            oc_s2;
    oc_state_t       state;
    oc_state_t       state_next;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_next;
    logic [STATUS_W-1:0] status_next;

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_left (
        .clk(clk), .rst_n(rst_n), .raw(ir_left), .level_next(left_next)
    );
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_center (
        .clk(clk), .rst_n(rst_n), .raw(ir_center), .level_next(center_next)
    );
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_right (
        .clk(clk), .rst_n(rst_n), .raw(ir_right), .level_next(right_next)
    );

`ifndef OC_STICKY_EN
    logic unused_oc_clear;
    assign unused_oc_clear = oc_clear;
`endif

    // The enum value OC_HOLD is qualified because the hold-length parameter
    // shares its name.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            OC_IDLE: begin
                if (oc_s2) state_next = OC_TRIP;
            end
            OC_TRIP: begin
                if (!oc_s2) begin
                    state_next = sensor_status_pkg::OC_HOLD;
                    hold_next  = HW'(OC_HOLD - 1);
                end
            end
            sensor_status_pkg::OC_HOLD: begin
                if (oc_s2) begin
                    state_next = OC_TRIP;
                end else if (hold_cnt == '0) begin
`ifdef OC_STICKY_EN
                    state_next = OC_LATCHED;
`else
                    state_next = OC_IDLE;
`endif
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
`ifdef OC_STICKY_EN
            OC_LATCHED: begin
                if (oc_s2) begin
                    state_next = OC_TRIP;
                end else if (oc_clear) begin
                    state_next = OC_IDLE;
                end
            end
`endif
            default: state_next = OC_IDLE;
        endcase
    end

    // Status is registered from next-state values, so qualification of any
    // bit becomes visible at the same edge it is decided.
    always_comb begin
        status_next             = '0;
        status_next[BIT_LEFT]   = left_next;
        status_next[BIT_CENTER] = center_next;
        status_next[BIT_RIGHT]  = right_next;
        status_next[BIT_OC]     = (state_next != OC_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oc_s1          <= 1'b0;
            oc_s2          <= 1'b0;
            state          <= OC_IDLE;
            hold_cnt       <= '0;
            status         <= '0;
            status_changed <= 1'b0;
        end else begin
            oc_s1          <= oc_raw;
            oc_s2          <= oc_s1;
            state          <= state_next;
            hold_cnt       <= hold_next;
            status         <= status_next;
            status_changed <= (status_next != status);
        end
    end

endmodule

// File: tb/tb_sensor_status_conditioner.sv
// tb/tb_sensor_status_conditioner.sv - table-driven bench for sensor_status_conditioner
module tb_sensor_status_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_left = 1'b0;
    logic       ir_center = 1'b0;
    logic       ir_right = 1'b0;
    logic       oc_raw = 1'b0;
    logic       oc_clear = 1'b0;
    logic [3:0] status;
    logic       status_changed;

    int total = 0;
    int bad = 0;

`ifdef OC_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [2:0] ir;
        logic       oc;
        logic       clr;
        logic       rn;
        logic [3:0] exp_s;
        logic       exp_c;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    sensor_status_conditioner #(.DB_CYCLES(4), .OC_HOLD(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ir_left(ir_left),
        .ir_center(ir_center),
        .ir_right(ir_right),
        .oc_raw(oc_raw),
        .oc_clear(oc_clear),
        .status(status),
        .status_changed(status_changed)
    );

    // n rows with the same inputs; all but the last expect s_mid and no pulse.
    task automatic add(input logic [2:0] ir, input logic oc, input logic clr, input logic rn,
                       input int n, input logic [3:0] s_mid, input logic [3:0] s_last,
                       input logic c_last);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.ir    = ir;
            v.oc    = oc;
            v.clr   = clr;
            v.rn    = rn;
            v.exp_s = (i == n - 1) ? s_last : s_mid;
            v.exp_c = (i == n - 1) ? c_last : 1'b0;
            vq.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all IR high, then release: 1110 six edges later
        add(3'b111, 0, 0, 0, 2, 4'b0000, 4'b0000, 0);
        add(3'b111, 0, 0, 1, 6, 4'b0000, 4'b1110, 1);
        add(3'b111, 0, 0, 1, 1, 4'b1110, 4'b1110, 0);
        // all low, then left alone
        add(3'b000, 0, 0, 1, 6, 4'b1110, 4'b0000, 1);
        add(3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
        add(3'b100, 0, 0, 1, 6, 4'b0000, 4'b1000, 1);
        add(3'b100, 0, 0, 1, 1, 4'b1000, 4'b1000, 0);
        // 3-cycle center glitch is filtered
        add(3'b110, 0, 0, 1, 3, 4'b1000, 4'b1000, 0);
        add(3'b100, 0, 0, 1, 8, 4'b1000, 4'b1000, 0);
        // left and right qualify together: one step, one pulse
        add(3'b000, 0, 0, 1, 6, 4'b1000, 4'b0000, 1);
        add(3'b101, 0, 0, 1, 6, 4'b0000, 4'b1010, 1);
        add(3'b101, 0, 0, 1, 2, 4'b1010, 4'b1010, 0);
        add(3'b000, 0, 0, 1, 6, 4'b1010, 4'b0000, 1);
        add(3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
        // 1-cycle OC pulse: set at edge 3, cleared (or latched) at edge 12
        add(3'b000, 1, 0, 1, 1, 4'b0000, 4'b0000, 0);
        add(3'b000, 0, 0, 1, 2, 4'b0000, 4'b0001, 1);
        add(3'b000, 0, 0, 1, 9, 4'b0001, STICKY ? 4'b0001 : 4'b0000, !STICKY);
        add(3'b000, 0, 1, 1, 1, STICKY ? 4'b0001 : 4'b0000, 4'b0000, STICKY);
        add(3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
        // reassert during HOLD cycle 5: flag never drops, full hold restarts
        add(3'b000, 1, 0, 1, 1, 4'b0000, 4'b0000, 0);
        add(3'b000, 0, 0, 1, 2, 4'b0000, 4'b0001, 1);
        add(3'b000, 0, 0, 1, 4, 4'b0001, 4'b0001, 0);
        add(3'b000, 1, 0, 1, 1, 4'b0001, 4'b0001, 0);
        add(3'b000, 0, 1, 1, 11, 4'b0001, STICKY ? 4'b0001 : 4'b0000, !STICKY);
        add(3'b000, 0, 1, 1, 1, STICKY ? 4'b0001 : 4'b0000, 4'b0000, STICKY);
        add(3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
        // reset mid-HOLD with IR high, then OC held high across release
        add(3'b111, 0, 0, 1, 6, 4'b0000, 4'b1110, 1);
        add(3'b111, 1, 0, 1, 1, 4'b1110, 4'b1110, 0);
        add(3'b111, 0, 0, 1, 2, 4'b1110, 4'b1111, 1);
        add(3'b111, 0, 0, 1, 3, 4'b1111, 4'b1111, 0);
        add(3'b111, 1, 0, 0, 1, 4'b0000, 4'b0000, 0);
        add(3'b111, 1, 0, 1, 3, 4'b0000, 4'b0001, 1);
        add(3'b111, 1, 0, 1, 3, 4'b0001, 4'b1111, 1);

        for (int i = 0; i < vq.size(); i++) begin
            {ir_left, ir_center, ir_right} = vq[i].ir;
            oc_raw   = vq[i].oc;
            oc_clear = vq[i].clr;
            rst_n    = vq[i].rn;
            cyc();
            check($sformatf("row%0d status", i), status, vq[i].exp_s);
            check($sformatf("row%0d changed", i), {3'b000, status_changed}, {3'b000, vq[i].exp_c});
        end

`ifdef OC_STICKY_EN
        // clear while synced OC is high is ignored
        oc_raw   = 1'b1;
        oc_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("sticky_clr_in_trip%0d", i), status, 4'b1111);
        end
        // release: hold expires into LATCHED and the flag stays set
        oc_raw   = 1'b0;
        oc_clear = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            check($sformatf("sticky_latched%0d", i), status, 4'b1111);
        end
        oc_clear = 1'b1;
        cyc();
        check("sticky_clear_status", status, 4'b1110);
        check("sticky_clear_pulse", {3'b000, status_changed}, 4'b0001);
        oc_clear = 1'b0;
        cyc();
        check("sticky_after_clear", status, 4'b1110);
        check("sticky_after_clear_pulse", {3'b000, status_changed}, 4'b0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
